// File: rtl/gate_input_debounce_if.sv
// rtl/gate_input_debounce_if.sv - pad-level inputs and debounced outputs of the gate input stage
//
// Bundles the per-channel signals exchanged between the pad side and the
// debounce stage. The stimulus/pad side uses the master modport; the debounce
// block uses the slave modport.
//   ena        count enable (debounce state holds when 0)
//   raw_in     unsynchronized pad levels, one bit per channel
//   level_out  debounced level per channel
//   rise_out   one-cycle strobe on an accepted 0->1
//   fall_out   one-cycle strobe on an accepted 1->0
//   busy_out   channel is counting toward a level change
interface gate_input_debounce_if #(
  parameter int CHANNELS = 2
);
  logic                ena;
  logic [CHANNELS-1:0] raw_in;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] rise_out;
  logic [CHANNELS-1:0] fall_out;
  logic [CHANNELS-1:0] busy_out;

  modport master (
    output ena,
    output raw_in,
    input  level_out,
    input  rise_out,
    input  fall_out,
    input  busy_out
  );

  modport slave (
    input  ena,
    input  raw_in,
    output level_out,
    output rise_out,
    output fall_out,
    output busy_out
  );
endinterface

// File: rtl/gate_input_debounce.sv
// rtl/gate_input_debounce.sv - per-channel synchronizer and counter debouncer feeding the NAND gate operands
//
// Each channel: two-flop synchronizer, then a consecutive-sample counter that
// accepts a new level only after it has persisted DEBOUNCE_CYCLES enabled
// cycles. Channel 0 drives gate operand A, channel 1 drives operand B.
//   clk      sole clock
//   rst_n    asynchronous active-low reset
//   gate_if  slave side of gate_input_debounce_if (ena, raw_in in;
//            level_out, rise_out, fall_out, busy_out out)
module gate_input_debounce #(
  parameter int CHANNELS        = 2,
  parameter int CNT_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gate_input_debounce_if.slave   gate_if
);

  // Counter value on which the pending level is accepted.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [CHANNELS-1:0]  s1_q;
  logic [CHANNELS-1:0]  s2_q;
  logic [CHANNELS-1:0]  level_q;
  logic [CHANNELS-1:0]  level_d;
  logic [CHANNELS-1:0]  rise_q;
  logic [CHANNELS-1:0]  rise_d;
  logic [CHANNELS-1:0]  fall_q;
  logic [CHANNELS-1:0]  fall_d;
  logic [CHANNELS-1:0]  busy;
  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];

  // Synchronizer flops sample every edge; only the debounce state obeys ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= gate_if.raw_in;
      s2_q    <= s1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    busy    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    for (int i = 0; i < CHANNELS; i++) begin
      busy[i] = (cnt_q[i] != '0);
      if (gate_if.ena) begin
        if (s2_q[i] == level_q[i]) begin
          // Input agrees with the accepted level: a bounce back aborts any count.
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          // Strobes are registered alongside level so they coincide with it.
          level_d[i] = s2_q[i];
          cnt_d[i]   = '0;
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign gate_if.level_out = level_q;
  assign gate_if.rise_out  = rise_q;
  assign gate_if.fall_out  = fall_q;
  assign gate_if.busy_out  = busy;

endmodule

// File: tb/tb_gate_input_debounce.sv
// tb/tb_gate_input_debounce.sv - scoreboard bench for gate_input_debounce with DEBOUNCE_CYCLES 4 and 1
module tb_gate_input_debounce;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [1:0] raw;

  int checks;
  int errors;
  int cyc;

  gate_input_debounce_if #(.CHANNELS(2)) if4 ();
  gate_input_debounce_if #(.CHANNELS(2)) if1 ();

  assign if4.raw_in = raw;
  assign if4.ena    = ena;
  assign if1.raw_in = raw;
  assign if1.ena    = ena;

  gate_input_debounce #(
    .CHANNELS(2), .CNT_WIDTH(8), .DEBOUNCE_CYCLES(4)
  ) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .gate_if (if4)
  );

  gate_input_debounce #(
    .CHANNELS(2), .CNT_WIDTH(8), .DEBOUNCE_CYCLES(1)
  ) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .gate_if (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: [cfg][channel]; cfg 0 -> window 4, cfg 1 -> window 1.
  int dcfg  [2];
  int m_s1  [2][2];
  int m_s2  [2][2];
  int m_lvl [2][2];
  int m_run [2][2];   // consecutive enabled samples disagreeing with m_lvl
  int m_rise[2][2];
  int m_fall[2][2];

  // Expected observation, packed as {level[1:0], rise[1:0], fall[1:0], busy[1:0]}.
  logic [7:0] exp_q4[$];
  logic [7:0] exp_q1[$];

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_rise[c][ch] = 0;
        m_fall[c][ch] = 0;
        if (!rst_n) begin
          m_s1[c][ch]  = 0;
          m_s2[c][ch]  = 0;
          m_lvl[c][ch] = 0;
          m_run[c][ch] = 0;
        end else begin
          if (ena) begin
            if (m_s2[c][ch] == m_lvl[c][ch]) begin
              m_run[c][ch] = 0;
            end else begin
              m_run[c][ch] = m_run[c][ch] + 1;
              if (m_run[c][ch] == dcfg[c]) begin
                m_lvl[c][ch] = m_s2[c][ch];
                if (m_s2[c][ch] != 0) m_rise[c][ch] = 1;
                else                  m_fall[c][ch] = 1;
                m_run[c][ch] = 0;
              end
            end
          end
          m_s2[c][ch] = m_s1[c][ch];
          m_s1[c][ch] = int'(raw[ch]);
        end
      end
    end
  endtask

  function automatic logic [7:0] model_obs(input int c);
    logic [1:0] l, r, f, b;
    for (int ch = 0; ch < 2; ch++) begin
      l[ch] = (m_lvl[c][ch] != 0);
      r[ch] = (m_rise[c][ch] != 0);
      f[ch] = (m_fall[c][ch] != 0);
      b[ch] = (m_run[c][ch] != 0);
    end
    return {l, r, f, b};
  endfunction

  function automatic logic [7:0] got4();
    return {if4.level_out, if4.rise_out, if4.fall_out, if4.busy_out};
  endfunction

  function automatic logic [7:0] got1();
    return {if1.level_out, if1.rise_out, if1.fall_out, if1.busy_out};
  endfunction

  task automatic compare(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got lvl=%b rise=%b fall=%b busy=%b required lvl=%b rise=%b fall=%b busy=%b",
               name, cyc, got[7:6], got[5:4], got[3:2], got[1:0],
               exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  // One clock cycle of stimulus: drive on the falling edge, then advance the
  // model on the rising edge and queue what the DUTs should show afterwards.
  task automatic step(input logic [1:0] r, input logic e, input logic rn);
    @(negedge clk);
    raw   = r;
    ena   = e;
    rst_n = rn;
    if (!rn) begin
      #1;
      compare("reset_async_d4", got4(), 8'h00);
      compare("reset_async_d1", got1(), 8'h00);
    end
    @(posedge clk);
    model_edge();
    exp_q4.push_back(model_obs(0));
    exp_q1.push_back(model_obs(1));
  endtask

  task automatic hold(input logic [1:0] r, input logic e, input int n);
    for (int k = 0; k < n; k++) step(r, e, 1'b1);
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q4.size() > 0) compare("outputs_d4", got4(), exp_q4.pop_front());
      if (exp_q1.size() > 0) compare("outputs_d1", got1(), exp_q1.pop_front());
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    dcfg[0] = 4;
    dcfg[1] = 1;
    for (int c = 0; c < 2; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_s1[c][ch] = 0; m_s2[c][ch] = 0; m_lvl[c][ch] = 0;
        m_run[c][ch] = 0; m_rise[c][ch] = 0; m_fall[c][ch] = 0;
      end
    end
    raw   = 2'b00;
    ena   = 1'b1;
    rst_n = 1'b0;

    // Reset with both pads high: nothing may leak through.
    for (int k = 0; k < 3; k++) step(2'b11, 1'b1, 1'b0);
    hold(2'b00, 1'b1, 6);

    // Clean rise on channel 0.
    hold(2'b01, 1'b1, 10);

    // Channel 1 bounce shorter than the window, then settle high and fall.
    hold(2'b11, 1'b1, 3);
    hold(2'b01, 1'b1, 8);
    hold(2'b11, 1'b1, 10);
    hold(2'b01, 1'b1, 10);

    // Enable dropped for 10 cycles in the middle of a channel 0 fall.
    hold(2'b00, 1'b1, 3);
    hold(2'b00, 1'b0, 10);
    hold(2'b00, 1'b1, 8);

    // Reset in the middle of a count with channel 0 held high.
    hold(2'b01, 1'b1, 4);
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    hold(2'b01, 1'b1, 10);
    hold(2'b00, 1'b1, 10);

    // Both channels change on the same edge; channel 1 bounces once.
    hold(2'b11, 1'b1, 2);
    hold(2'b01, 1'b1, 1);
    hold(2'b11, 1'b1, 12);
    hold(2'b00, 1'b1, 10);

    // Randomized segments: random level held a few cycles, sparse ena drops and resets.
    for (int s = 0; s < 500; s++) begin
      logic [1:0] r;
      int         n;
      r = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 299) == 0)
          step(r, 1'b1, 1'b0);
        else
          step(r, ($urandom_range(0, 7) != 0), 1'b1);
      end
    end

    hold(2'b00, 1'b1, 2);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q4.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending required 0/0", exp_q4.size(), exp_q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_input_debounce.md
# gate_input_debounce

Input-conditioning stage that sits directly upstream of the NAND gate block and produces its clean `A`/`B` operands. Each channel takes a raw, asynchronous pad level from `ui_in`, synchronizes it into the `clk` domain, and debounces it with a consecutive-sample counter. It then presents a stable level plus one-cycle rise and fall strobes. Channels are fully independent.

## Interface

- `CHANNELS`, default 2: number of independent input channels (bit 0 → gate input A, bit 1 → gate input B).
- `CNT_WIDTH`, default 8: width of each channel's debounce counter.
- `DEBOUNCE_CYCLES`, default 200: consecutive enabled cycles a new level must persist before acceptance. Legal range is 1 .. 2^CNT_WIDTH−1.

- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  count enable. When 0, debounce state holds.
- `raw_in`  in  CHANNELS  unsynchronized pad levels.
- `level_out`  out  CHANNELS  debounced level, feeds gate operands.
- `rise_out`  out  CHANNELS  one-cycle strobe on accepted 0→1.
- `fall_out`  out  CHANNELS  one-cycle strobe on accepted 1→0.
- `busy_out`  out  CHANNELS  channel currently counting toward a level change.

## Operation

- Per channel there is a two-flop synchronizer `s1 ← raw_in[i]`, `s2 ← s1`. It samples on every clock edge regardless of `ena`.
- Per-channel state is the counter `cnt` (CNT_WIDTH bits) and the register `level`.
  - IDLE: `cnt == 0`.
  - COUNT: `cnt != 0`.
- On each rising `clk` edge with `ena = 1`, evaluated in this order:
  - If `s2 == level`: `cnt ← 0`. This covers a bounce returning to the old level mid-count, which aborts the count with no output change.
  - Else if `cnt == DEBOUNCE_CYCLES−1`: `level ← s2`, `cnt ← 0`. Assert `rise_out[i]` if `s2 == 1`, otherwise `fall_out[i]`.
  - Else: `cnt ← cnt+1`.
- With `ena = 0`:
  - `cnt` and `level` hold.
  - `rise_out` and `fall_out` are 0.
  - Synchronizer flops keep sampling.
- `busy_out[i] = (cnt != 0)`, combinational from the register.
- `rise_out` and `fall_out` are registered, high for exactly one cycle, and asserted on the same edge that updates `level_out`. They are never both high on one channel.
- `DEBOUNCE_CYCLES = 1` degenerates to a pure 3-flop-latency synchronizer, with strobes still generated.
- The counter never exceeds DEBOUNCE_CYCLES−1, so no wrap is possible within the legal range.

## Timing

- Reset (`rst_n` low, asynchronous): `s1`, `s2`, `cnt`, `level` = 0. All outputs are 0: `level_out`, `rise_out`, `fall_out`, `busy_out`.
- Reset deassertion must be used synchronously (internal flops release on the next edge). No glitch on outputs at release.
- Latency: a raw change stable before edge 0 reaches `s2` after edge 1. `level_out` and the strobe update after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges total with `ena` held 1.
- `busy_out` rises after edge 2 (when DEBOUNCE_CYCLES > 1) and falls on the edge that updates `level_out`.
- A raw pulse shorter than DEBOUNCE_CYCLES enabled cycles (after sync) is fully rejected.
- `ena` low mid-count extends latency by exactly the number of disabled cycles, provided `s2` is unchanged.
- Reset mid-count discards progress. If `raw_in` is high at release, a full debounce restarts and `rise_out` fires DEBOUNCE_CYCLES+2 edges after release.
- Simultaneous events on different channels are independent. Strobes may coincide across channels.

## Test plan

- Reset values: assert `rst_n = 0` with `raw_in = 2'b11` → all outputs 0 immediately and throughout reset; no strobe during reset.
- Clean rise (DEBOUNCE_CYCLES = 4, `ena = 1`): `raw_in[0]` 0→1 before edge 0 → `busy_out[0] = 1` after edge 2, and `level_out[0] = 1` with `rise_out[0] = 1` after edge 5. `rise_out[0]` is 0 after edge 6, and `busy_out[0] = 0` after edge 5.
- Bounce rejection (DEBOUNCE_CYCLES = 4): `raw_in[1]` high for 3 cycles then low → `level_out[1]` stays 0, no strobe, `busy_out[1]` returns to 0. Then a 1→0 transition from a settled 1 → `fall_out[1]` for one cycle, 6 edges later.
- Enable hold: start a rise, drop `ena` for 10 cycles mid-count → `cnt` and `busy_out` frozen, no strobe. The update lands exactly 10 edges later than nominal.
- Reset mid-count: pulse `rst_n` low during COUNT with `raw_in[0]` held 1 → outputs clear asynchronously, and `rise_out[0]` fires 6 edges after release (DEBOUNCE_CYCLES = 4).
- Independence: toggle both channels on the same edge, with channel 1 bouncing once → channel 0 strobes on schedule and channel 1 accepts its change only after its own full stable window.
